// File: rtl/mii_gmii_pkg.sv
// mii_gmii_pkg: shared state type and preamble/SFD symbol constants for the MII/GMII receive path.
package mii_gmii_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, END, DISCARD} rx_state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] PRE_NIBBLE    = 4'h5;
  localparam logic [3:0] SFD_NIBBLE    = 4'hD;
endpackage

// File: rtl/mii_gmii_rx_ctrl_asm.sv
// mii_nibble_assembler: pairs MII nibbles (low first) into bytes; odd_o flags a dangling low nibble.
module mii_nibble_assembler (
  input  logic       rx_clk_i,
  input  logic       reset_i,
  input  logic [3:0] nibble_i,
  input  logic       strobe_i,
  input  logic       clr_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       odd_o
);
  logic [3:0] low_q;
  logic       phase_q;
  always_ff @(posedge rx_clk_i) begin
    if (reset_i || clr_i) begin
      low_q   <= '0;
      phase_q <= 1'b0;
    end else if (strobe_i) begin
      phase_q <= ~phase_q;
      if (!phase_q) low_q <= nibble_i;
    end
  end
  assign byte_o       = {nibble_i, low_q};
  assign byte_valid_o = strobe_i & phase_q;
  assign odd_o        = phase_q;
endmodule

// File: rtl/mii_gmii_rx_ctrl.sv
// mii_gmii_rx_ctrl: strips preamble/SFD, emits qualified frame bytes with sof/eof/len/err.
// Define MII_GMII_RX_STATS_EN to add saturating ok/err/drop frame counters.
module mii_gmii_rx_ctrl
  import mii_gmii_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int MAX_PRE = 15,
  parameter int LEN_W   = $clog2(MAX_LEN + 2)
) (
  input  logic             rx_clk_i,
  input  logic             reset_i,
  input  logic             gmii_mode_i,
  input  logic             rx_dv_i,
  input  logic [7:0]       rxd_i,
  input  logic             rx_er_i,
  input  logic             col_rx_i,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             err_o,
  output logic [LEN_W-1:0] len_o,
  output logic             busy_o
`ifdef MII_GMII_RX_STATS_EN
  ,
  output logic [31:0]      frames_ok_o,
  output logic [31:0]      frames_err_o,
  output logic [31:0]      frames_drop_o
`endif
);
  localparam int PW = $clog2(2 * MAX_PRE + 2);
  localparam logic [PW-1:0]    PRE_LIM_G = PW'(MAX_PRE);
  localparam logic [PW-1:0]    PRE_LIM_M = PW'(2 * MAX_PRE);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);

  rx_state_t        state_q, state_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    pre_q, pre_d, pre_inc;
  logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, sof_q, sof_d;
  logic             gmii, pre_sym, sfd_sym, byte_ok;
  logic [7:0]       byte_in, asm_byte;
  logic             asm_valid, asm_odd;

  mii_nibble_assembler u_asm (
    .rx_clk_i     (rx_clk_i),
    .reset_i      (reset_i),
    .nibble_i     (rxd_i[3:0]),
    .strobe_i     (state_q == DATA && rx_dv_i && !mode_q),
    .clr_i        (state_q != DATA),
    .byte_o       (asm_byte),
    .byte_valid_o (asm_valid),
    .odd_o        (asm_odd)
  );

  // In IDLE the first symbol is judged with the live mode pin; afterwards the latched mode rules.
  assign gmii    = (state_q == IDLE) ? gmii_mode_i : mode_q;
  assign pre_sym = gmii ? (rxd_i == PREAMBLE_BYTE) : (rxd_i[3:0] == PRE_NIBBLE);
  assign sfd_sym = gmii ? (rxd_i == SFD_BYTE) : (rxd_i[3:0] == SFD_NIBBLE && state_q == PREAMBLE);
  assign pre_inc = pre_q + 1'b1;
  assign cnt_inc = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 1'b1;
  assign byte_ok = rx_dv_i && (gmii || asm_valid);
  assign byte_in = gmii ? rxd_i : asm_byte;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    case (state_q)
      IDLE, PREAMBLE: begin
        if (state_q == IDLE) mode_d = gmii_mode_i;
        if (!rx_dv_i) state_d = IDLE;
        else if (sfd_sym) begin
          state_d = DATA;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (!pre_sym || pre_inc > (gmii ? PRE_LIM_G : PRE_LIM_M)) state_d = DISCARD;
        else begin
          state_d = PREAMBLE;
          pre_d   = pre_inc;
        end
      end
      DATA: begin
        if (!rx_dv_i) state_d = END;
        err_d = err_q | col_rx_i | (rx_er_i & rx_dv_i);
        if (byte_ok) begin
          cnt_d = cnt_inc;
          if (cnt_q < LEN_MAX) begin
            valid_d = 1'b1;
            data_d  = byte_in;
            sof_d   = (cnt_q == '0);
          end else err_d = 1'b1;
        end
      end
      END:     state_d = IDLE;
      DISCARD: state_d = rx_dv_i ? DISCARD : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != PREAMBLE) pre_d = '0;
  end

  always_ff @(posedge rx_clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sof_o   = sof_q;
  assign eof_o   = (state_q == END);
  assign len_o   = eof_o ? cnt_q : '0;
  // asm_odd still holds the DATA-time phase during END, exposing a dribble nibble.
  assign err_o   = eof_o & (err_q | (cnt_q > LEN_MAX) | (cnt_q < LEN_MIN) | asm_odd);
  assign busy_o  = (state_q != IDLE);

`ifdef MII_GMII_RX_STATS_EN
  logic [31:0] ok_q, bad_q, drop_q;
  always_ff @(posedge rx_clk_i) begin
    if (reset_i) begin
      ok_q   <= '0;
      bad_q  <= '0;
      drop_q <= '0;
    end else begin
      if (eof_o && !err_o && ~&ok_q) ok_q <= ok_q + 32'd1;
      if (eof_o && err_o && ~&bad_q) bad_q <= bad_q + 32'd1;
      if (state_d == DISCARD && state_q != DISCARD && ~&drop_q) drop_q <= drop_q + 32'd1;
    end
  end
  assign frames_ok_o   = ok_q;
  assign frames_err_o  = bad_q;
  assign frames_drop_o = drop_q;
`endif
endmodule

// File: doc/mii_gmii_rx_ctrl.md
Name: mii_gmii_rx_ctrl

Overview:
Receive-side frame sequencer behind the registered MII/GMII input stage, clocked on rx_clk_i.
- Strips preamble and SFD.
- In MII mode, assembles nibbles into bytes.
- Emits a byte stream with start marker.
- Ends each frame with a status strobe carrying length and error.
- Qualifies each frame against rx_er, collision, length limits and nibble alignment before the MAC receive logic consumes it.

Parameters:
MAX_LEN, 1518, max accepted frame bytes after SFD (FCS included)
MIN_LEN, 64, min accepted frame bytes after SFD
MAX_PRE, 15, max preamble bytes tolerated before SFD
LEN_W, $clog2(MAX_LEN+2), length counter width (derived, not overridden)

Ports:
rx_clk_i  in  1  receive clock; all logic single-clock
reset_i  in  1  synchronous, active-high reset
gmii_mode_i  in  1  1 = GMII (byte per cycle); 0 = MII (nibble on rxd_i[3:0], low nibble first)
rx_dv_i  in  1  registered receive data valid
rxd_i  in  8  registered receive data
rx_er_i  in  1  registered receive error
col_rx_i  in  1  registered collision (rx domain)
data_o  out  8  received frame byte
valid_o  out  1  data_o valid, one-cycle pulse per byte
sof_o  out  1  high with first byte after SFD
eof_o  out  1  one-cycle end-of-frame strobe, valid_o=0 in that cycle
err_o  out  1  frame error, meaningful only while eof_o=1
len_o  out  LEN_W  byte count of the frame, meaningful only while eof_o=1
busy_o  out  1  state != IDLE

Behaviour:
Reset:
- Synchronous and active-high.
- All outputs, counters and nibble phase go to 0; state goes to IDLE.
- Reset mid-frame drops the frame silently (no eof_o). If rx_dv_i is still high after reset, the FSM enters PREAMBLE, sees non-preamble data and goes to DISCARD.

Mode: gmii_mode_i is latched on the IDLE->PREAMBLE transition. Changes inside a frame are ignored.

States:
- IDLE: on rx_dv_i=1, go to PREAMBLE. The current byte/nibble is evaluated as a preamble symbol in the same cycle.
- PREAMBLE (GMII):
  - 0x55: increment the preamble counter.
  - 0xD5: go to DATA.
  - Any other byte, or preamble count > MAX_PRE: go to DISCARD.
- PREAMBLE (MII):
  - Nibble 0x5: continue.
  - Nibble 0xD with previous nibble 0x5: SFD; go to DATA with nibble phase cleared. This tolerates odd preamble alignment.
  - Other nibble, or nibble count > 2*MAX_PRE: go to DISCARD.
- In any state, rx_dv_i=0 before SFD: return to IDLE with no output.
- DATA:
  - Each completed byte is registered to data_o with valid_o=1.
  - GMII latency: 1 cycle from rxd_i.
  - MII latency: 1 cycle after the high nibble.
  - The first byte also asserts sof_o.
  - The length counter increments per byte and saturates at MAX_LEN+1.
  - Once the count exceeds MAX_LEN, no further valid_o is issued; the frame is flagged error.
  - rx_dv_i=0 goes to END.
- END: one cycle.
  - eof_o=1 and len_o=count.
  - err_o = OR of: rx_er_i seen in DATA; col_rx_i seen in DATA; count > MAX_LEN; count < MIN_LEN; MII nibble phase odd at rx_dv fall (dribble).
  - Next state IDLE. If rx_dv_i is already high in that cycle, it is handled in IDLE on the next cycle.
- DISCARD: no outputs; wait for rx_dv_i=0, then IDLE.

Other rules:
- rx_er_i with rx_dv_i=0 (false carrier / extension) is ignored in all states.
- Simultaneous rx_er_i and rx_dv_i fall in the last DATA cycle: the error counts.

Optional Feature:
MII_GMII_RX_STATS_EN:
- Defined: adds outputs frames_ok_o[31:0], frames_err_o[31:0] and frames_drop_o[31:0].
- Counters are saturating and cleared by reset_i.
- frames_ok_o / frames_err_o increment on eof_o with err_o=0 / 1.
- frames_drop_o increments on each entry to DISCARD.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package mii_gmii_pkg holds:
  - rx_state_t enum (IDLE, PREAMBLE, DATA, END, DISCARD)
  - PREAMBLE_BYTE = 8'h55, SFD_BYTE = 8'hD5, PRE_NIBBLE = 4'h5, SFD_NIBBLE = 4'hD
- Sub-module mii_nibble_assembler:
  - Inputs: nibble, strobe, phase clear.
  - Outputs: byte, byte_valid, odd_phase.
  - Bypassed in GMII mode.

Test Plan:
- GMII: 7x0x55, 0xD5, 64 bytes 0x00..0x3F, rx_dv falls -> 64 valid_o pulses, data_o=0x00..0x3F, sof_o with 0x00, eof_o next cycle, len_o=64, err_o=0.
- MII: same 64-byte frame as nibbles, low first, including one extra odd 0x5 preamble nibble -> identical bytes, len_o=64, err_o=0. Frame ending after an extra half byte -> err_o=1 (dribble).
- GMII 60-byte frame -> len_o=60, err_o=1 (runt). 1519-byte frame -> exactly 1518 valid_o, len_o=1519, err_o=1.
- rx_er_i pulse on byte 10 of a 100-byte frame -> all 100 bytes output, eof_o with len_o=100, err_o=1. col_rx_i pulse in DATA -> same result.
- Preamble 0x55,0x55,0xAA -> no valid_o/eof_o; DISCARD until rx_dv low. 16x0x55 then SFD -> dropped. frames_drop_o increments when MII_GMII_RX_STATS_EN is defined.
- reset_i asserted at byte 30 of a frame, released with rx_dv still high -> outputs 0, no eof_o, DISCARD to frame end. The next clean frame is received correctly.
